// File: rtl/qrd_pkg.sv
// Shared definitions for the QR-decomposition input staging path.
//   - FSM state encodings for the input-skew controller
//   - cplx_t: one complex sample at the default element width
//   - lane_delay(): per-lane staircase depth for a given size and direction
package qrd_pkg;

    localparam int unsigned CPLX_W = 12;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RECV = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

    typedef struct packed {
        logic signed [CPLX_W-1:0] r;
        logic signed [CPLX_W-1:0] i;
    } cplx_t;

    // Lane k waits k beats (dir 0) or N-1-k beats (dir 1) before its output register.
    function automatic int unsigned lane_delay(input int unsigned k,
                                               input int unsigned n,
                                               input int unsigned dir);
        return (dir == 0) ? k : (n - 1 - k);
    endfunction

endpackage

// File: rtl/qrd_lane_delay.sv
// One skew lane: DEPTH shift stages of {valid, last, data} followed by an
// output register. DEPTH may be 0, in which case only the output register remains.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_last     beat marker and end-of-matrix marker entering the lane
//   in_data  [W]         payload entering the lane
//   out_valid/out_last   registered markers leaving the lane
//   out_data [W]         registered payload leaving the lane
module qrd_lane_delay #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic         out_last,
    output logic [W-1:0] out_data
);

    localparam int unsigned SW = W + 2;

    logic [SW-1:0] stage_in;
    logic [SW-1:0] stage_out;

    assign stage_in = {in_valid, in_last, in_data};

    if (DEPTH == 0) begin : g_direct
        assign stage_out = stage_in;
    end else begin : g_shift
        logic [DEPTH-1:0][SW-1:0] sr;

        // Shift toward the top; truncation drops the oldest entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else begin
                sr <= (DEPTH*SW)'({sr, stage_in});
            end
        end

        assign stage_out = sr[DEPTH-1];
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= stage_out[SW-1];
            out_last  <= stage_out[SW-2];
            out_data  <= stage_out[W-1:0];
        end
    end

endmodule

// File: rtl/qrd_input_skew.sv
// Input staging for the QRD systolic array: captures one complex element per
// row lane per beat, re-times lanes into staircase order, enforces an idle gap
// after each matrix and flags beats offered while not ready.
//   clk, rst_n        clock, async active-low reset
//   in_valid          beat present on in_r/in_i
//   in_r, in_i        N lanes of IN_W-bit real/imag parts, lane k at [k*IN_W +: IN_W]
//   in_ready          beat accepted when in_valid && in_ready
//   skew_valid[N]     per-lane valid after skew
//   skew_r, skew_i    skewed real/imag parts, same packing as inputs
//   skew_last[N]      per-lane marker for the matrix's Nth beat
//   frame_done        one-cycle pulse after the slowest lane emits its last beat
//   ovf               sticky flag: in_valid seen while in_ready low
module qrd_input_skew
    import qrd_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IN_W     = 12,
    parameter int unsigned SKEW_DIR = 0,
    parameter int unsigned MIN_GAP  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [N*IN_W-1:0] in_r,
    input  logic [N*IN_W-1:0] in_i,
    output logic              in_ready,
    output logic [N-1:0]      skew_valid,
    output logic [N*IN_W-1:0] skew_r,
    output logic [N*IN_W-1:0] skew_i,
    output logic [N-1:0]      skew_last,
    output logic              frame_done,
    output logic              ovf
);

    localparam int unsigned BW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW       = 8;
    localparam int unsigned LW       = 2 * IN_W;
    localparam int unsigned MAX_LANE = (SKEW_DIR == 0) ? (N - 1) : 0;

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_next;
    logic [BW-1:0]     beat_cnt;
    logic [BW-1:0]     beat_next;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_next;

    logic              accept_c;
    logic              last_beat_c;

    logic              cap_valid;
    logic              cap_last;
    logic [N*IN_W-1:0] cap_r;
    logic [N*IN_W-1:0] cap_i;

    assign accept_c    = in_valid & in_ready;
    assign last_beat_c = (beat_cnt == BW'(N - 1));

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
            gap_cnt  <= gap_next;
            in_ready <= (state_next != ST_GAP);
        end
    end

    // Next-state logic: count beats, then hold off input for MIN_GAP cycles.
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        gap_next   = gap_cnt;
        case (state)
            ST_IDLE, ST_RECV: begin
                if (accept_c) begin
                    if (last_beat_c) begin
                        beat_next = '0;
                        if (MIN_GAP == 0) begin
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_GAP;
                            gap_next   = GW'(MIN_GAP);
                        end
                    end else begin
                        beat_next  = beat_cnt + BW'(1);
                        state_next = ST_RECV;
                    end
                end
            end
            ST_GAP: begin
                gap_next = gap_cnt - GW'(1);
                if (gap_cnt <= GW'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Common capture stage; bubbles enter the lanes as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_last  <= 1'b0;
            cap_r     <= '0;
            cap_i     <= '0;
        end else begin
            cap_valid <= accept_c;
            cap_last  <= accept_c & last_beat_c;
            if (accept_c) begin
                cap_r <= in_r;
                cap_i <= in_i;
            end
        end
    end

    // Per-lane staircase delay.
    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int unsigned DEPTH = lane_delay(k, N, SKEW_DIR);

        logic [LW-1:0] lane_data;

        qrd_lane_delay #(
            .DEPTH (DEPTH),
            .W     (LW)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (cap_valid),
            .in_last   (cap_last),
            .in_data   ({cap_r[k*IN_W +: IN_W], cap_i[k*IN_W +: IN_W]}),
            .out_valid (skew_valid[k]),
            .out_last  (skew_last[k]),
            .out_data  (lane_data)
        );

        assign skew_r[k*IN_W +: IN_W] = lane_data[LW-1 -: IN_W];
        assign skew_i[k*IN_W +: IN_W] = lane_data[IN_W-1:0];
    end

    // Status flags: end-of-matrix pulse from the slowest lane, sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            frame_done <= skew_valid[MAX_LANE] & skew_last[MAX_LANE];
            ovf        <= ovf | (in_valid & ~in_ready);
        end
    end

endmodule

// File: tb/tb_qrd_input_skew.sv
// Scoreboard bench for qrd_input_skew. Three instances: N=4/dir0/gap3 and
// N=4/dir1/gap3 share one stimulus bus, N=8/16-bit/gap0 has its own.
module tb_qrd_input_skew;

    localparam int INF = 1 << 30;

    typedef struct {
        int          cyc;
        logic [15:0] r;
        logic [15:0] i;
        logic        last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_bad = 0;

    logic         a_valid;
    logic [47:0]  a_r, a_i;
    logic         a0_rdy, a0_fd, a0_ovf, a1_rdy, a1_fd, a1_ovf;
    logic [3:0]   a0_sv, a0_sl, a1_sv, a1_sl;
    logic [47:0]  a0_sr, a0_si, a1_sr, a1_si;

    logic         b_valid;
    logic [127:0] b_r, b_i;
    logic         b_rdy, b_fd, b_ovf;
    logic [7:0]   b_sv, b_sl;
    logic [127:0] b_sr, b_si;

    exp_t         lane_q [24][$];
    int           fd_q   [3][$];
    int           ovf_from [3];

    qrd_input_skew #(.N(4), .IN_W(12), .SKEW_DIR(0), .MIN_GAP(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_r(a_r), .in_i(a_i),
        .in_ready(a0_rdy), .skew_valid(a0_sv), .skew_r(a0_sr), .skew_i(a0_si),
        .skew_last(a0_sl), .frame_done(a0_fd), .ovf(a0_ovf));

    qrd_input_skew #(.N(4), .IN_W(12), .SKEW_DIR(1), .MIN_GAP(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_r(a_r), .in_i(a_i),
        .in_ready(a1_rdy), .skew_valid(a1_sv), .skew_r(a1_sr), .skew_i(a1_si),
        .skew_last(a1_sl), .frame_done(a1_fd), .ovf(a1_ovf));

    qrd_input_skew #(.N(8), .IN_W(16), .SKEW_DIR(0), .MIN_GAP(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_r(b_r), .in_i(b_i),
        .in_ready(b_rdy), .skew_valid(b_sv), .skew_r(b_sr), .skew_i(b_si),
        .skew_last(b_sl), .frame_done(b_fd), .ovf(b_ovf));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int d, input int k,
                                input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d lane%0d cyc%0d: got %0h expected %0h", nm, d, k, cyc, act, exp);
        end
    endfunction

    // Lane k of beat b: base + 16k + b (4-lane group) or base + 256k + b (8-lane group).
    function automatic logic [127:0] mk(input int grp, input int base, input int b);
        logic [127:0] v;
        v = '0;
        if (grp == 0) begin
            for (int k = 0; k < 4; k++) v[k*12 +: 12] = 12'(base + 16*k + b);
        end else begin
            for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(base + 256*k + b);
        end
        return v;
    endfunction

    // Expected outputs of a beat driven in the current cycle: capture at the next
    // edge, D(k) stage edges, one output edge.
    function automatic void push_beat(input int d, input logic [127:0] r,
                                      input logic [127:0] i, input bit last);
        int   nl;
        int   dl;
        exp_t e;
        nl = (d == 2) ? 8 : 4;
        for (int k = 0; k < nl; k++) begin
            dl    = (d == 1) ? (nl - 1 - k) : k;
            e.cyc = cyc + 2 + dl;
            if (d == 2) begin
                e.r = r[k*16 +: 16];
                e.i = i[k*16 +: 16];
            end else begin
                e.r = {4'b0, r[k*12 +: 12]};
                e.i = {4'b0, i[k*12 +: 12]};
            end
            e.last = last;
            lane_q[d*8 + k].push_back(e);
        end
        if (last) fd_q[d].push_back(cyc + nl + 2);
    endfunction

    // One cycle of stimulus on a group; acc is the hand-predicted in_ready.
    task automatic cycle_drive(input int grp, input bit v, input logic [127:0] r,
                               input logic [127:0] i, input bit acc, input bit last);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (grp == 0) begin
            a_valid = v;
            a_r     = r[47:0];
            a_i     = i[47:0];
        end else begin
            b_valid = v;
            b_r     = r;
            b_i     = i;
        end
        if (v) begin
            for (int d = (grp == 0 ? 0 : 2); d <= (grp == 0 ? 1 : 2); d++) begin
                chk("in_ready", d, 0, (d == 0) ? a0_rdy : (d == 1) ? a1_rdy : b_rdy, acc);
                if (acc) push_beat(d, r, i, last);
                else if (ovf_from[d] == INF) ovf_from[d] = cyc + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        for (int q = 0; q < 24; q++) lane_q[q].delete();
        for (int d = 0; d < 3; d++) begin
            fd_q[d].delete();
            ovf_from[d] = INF;
        end
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every falling edge, compare each instance against its queues.
    logic         m_rd, m_fd, m_ov, m_v, m_l, m_ev, m_efd;
    logic [7:0]   m_sv, m_sl;
    logic [127:0] m_sr, m_si;
    logic [15:0]  m_r, m_i;
    exp_t         m_e;
    int           m_idx;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: begin
                    m_rd = a0_rdy; m_fd = a0_fd; m_ov = a0_ovf;
                    m_sv = {4'b0, a0_sv}; m_sl = {4'b0, a0_sl};
                    m_sr = {80'b0, a0_sr}; m_si = {80'b0, a0_si};
                end
                1: begin
                    m_rd = a1_rdy; m_fd = a1_fd; m_ov = a1_ovf;
                    m_sv = {4'b0, a1_sv}; m_sl = {4'b0, a1_sl};
                    m_sr = {80'b0, a1_sr}; m_si = {80'b0, a1_si};
                end
                default: begin
                    m_rd = b_rdy; m_fd = b_fd; m_ov = b_ovf;
                    m_sv = b_sv; m_sl = b_sl; m_sr = b_sr; m_si = b_si;
                end
            endcase
            if (!rst_n) begin
                chk("rst_in_ready", d, 0, m_rd, 1);
                chk("rst_valid", d, 0, m_sv, 0);
                chk("rst_last", d, 0, m_sl, 0);
                chk("rst_r", d, 0, m_sr, 0);
                chk("rst_i", d, 0, m_si, 0);
                chk("rst_frame_done", d, 0, m_fd, 0);
                chk("rst_ovf", d, 0, m_ov, 0);
            end else begin
                for (int k = 0; k < ((d == 2) ? 8 : 4); k++) begin
                    m_idx = d*8 + k;
                    m_ev  = (lane_q[m_idx].size() > 0) && (lane_q[m_idx][0].cyc == cyc);
                    m_v   = m_sv[k];
                    m_l   = m_sl[k];
                    m_r   = (d == 2) ? m_sr[k*16 +: 16] : {4'b0, m_sr[k*12 +: 12]};
                    m_i   = (d == 2) ? m_si[k*16 +: 16] : {4'b0, m_si[k*12 +: 12]};
                    chk("valid", d, k, m_v, m_ev);
                    if (m_ev) begin
                        m_e = lane_q[m_idx].pop_front();
                        chk("data_r", d, k, m_r, m_e.r);
                        chk("data_i", d, k, m_i, m_e.i);
                        chk("last", d, k, m_l, m_e.last);
                    end else begin
                        chk("last_idle", d, k, m_l, 0);
                    end
                end
                m_efd = (fd_q[d].size() > 0) && (fd_q[d][0] == cyc);
                if (m_efd) void'(fd_q[d].pop_front());
                chk("frame_done", d, 0, m_fd, m_efd);
                chk("ovf", d, 0, m_ov, (cyc >= ovf_from[d]));
            end
        end
    end

    logic [127:0] vr, vi;
    int           gap_pat [7] = '{1, 0, 1, 0, 0, 1, 1};
    int           bn;

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b0; a_r = '0; a_i = '0;
        b_valid = 1'b0; b_r = '0; b_i = '0;
        for (int d = 0; d < 3; d++) ovf_from[d] = INF;
        do_reset(3);

        // Matrix 1: lane k beat b = 16k+b, consecutive beats.
        for (int b = 0; b < 4; b++)
            cycle_drive(0, 1'b1, mk(0, 0, b), mk(0, 'h100, b), 1'b1, b == 3);
        // in_valid held through the 3-cycle gap: all dropped, ovf rises.
        for (int b = 0; b < 3; b++)
            cycle_drive(0, 1'b1, mk(0, 'h300, b), mk(0, 'h340, b), 1'b0, 1'b0);
        // Matrix 2 starts right after the gap; extreme bit patterns on lanes 0/1.
        for (int b = 0; b < 4; b++) begin
            vr = mk(0, 'h200, b);
            vi = mk(0, 'h280, b);
            vr[11:0] = 12'h800; vr[23:12] = 12'h7FF;
            vi[11:0] = 12'h7FF; vi[23:12] = 12'h800;
            cycle_drive(0, 1'b1, vr, vi, 1'b1, b == 3);
        end
        idle(4);

        // Matrix 3: beats at relative cycles 0, 2, 5, 6.
        bn = 0;
        for (int c = 0; c < 7; c++) begin
            if (gap_pat[c] == 1) begin
                cycle_drive(0, 1'b1, mk(0, 'h400, bn), mk(0, 'h480, bn), 1'b1, bn == 3);
                bn++;
            end else begin
                idle(1);
            end
        end
        idle(4);

        // Partial matrix discarded by reset, then a full matrix from beat 0.
        for (int b = 0; b < 2; b++)
            cycle_drive(0, 1'b1, mk(0, 'h600, b), mk(0, 'h680, b), 1'b1, 1'b0);
        do_reset(2);
        idle(1);
        for (int b = 0; b < 4; b++)
            cycle_drive(0, 1'b1, mk(0, 'h500, b), mk(0, 'h580, b), 1'b1, b == 3);
        idle(10);

        // 8x8, 16-bit, no gap: two matrices back to back.
        for (int b = 0; b < 16; b++)
            cycle_drive(1, 1'b1, mk(1, 'h8000, b), mk(1, 'h7F00, b), 1'b1, (b % 8) == 7);
        idle(14);

        for (int q = 0; q < 24; q++) chk("leftover_lane", q / 8, q % 8, lane_q[q].size(), 0);
        for (int d = 0; d < 3; d++) chk("leftover_frame_done", d, 0, fd_q[d].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
